fht_addr_gen: RTL

Address and twiddle sequencer for the radix-2 FHT core. On a start pulse it walks all log2(N) stages and every butterfly in each stage. Per butterfly it issues the coefficient-ROM address and the stage-zero flag to the sin/cos ROM block. One cycle later it presents the butterfly's data-RAM operand addresses with a valid strobe, aligned with the ROM's registered sin/cos output. It sits between the top-level control and the ROM block / butterfly datapath.

---
 rtl/fht_addr_gen_pkg.sv | 23 ++
 rtl/fht_bfly_idx.sv | 38 +++
 rtl/fht_addr_gen.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/fht_addr_gen_pkg.sv
// Shared types and index helpers for the radix-2 FHT address sequencer.
package fht_addr_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    localparam int DRAIN_CNT_W = 4;

    // Width of a stage number for a transform of 2^n_bit points.
    function automatic int stage_w(input int n_bit);
        return (n_bit <= 2) ? 1 : $clog2(n_bit);
    endfunction

    // Twiddle index for butterfly offset k in stage s: k * N / (2 * 2^s).
    function automatic logic [31:0] twiddle_idx(input logic [31:0] k, input int s, input int n_bit);
        return k << (n_bit - 1 - s);
    endfunction

endpackage

// File: rtl/fht_bfly_idx.sv
// Combinational mapping of (stage, butterfly) to operand addresses and twiddle ROM index.
module fht_bfly_idx
    import fht_addr_gen_pkg::*;
#(
    parameter int N_BIT = 8,
    parameter int A_BIT = N_BIT - 2,
    parameter int S_BIT = stage_w(N_BIT)
) (
    input  logic [S_BIT-1:0] s_i,
    input  logic [N_BIT-2:0] b_i,
    output logic [N_BIT-1:0] addr_a_o,
    output logic [N_BIT-1:0] addr_b_o,
    output logic [A_BIT-1:0] rom_addr_o,
    output logic             quad_o
);

    localparam logic [N_BIT-1:0] ONE = N_BIT'(1);

    logic [N_BIT-1:0] b_ext;
    logic [N_BIT-1:0] half;
    logic [N_BIT-1:0] k;
    logic [N_BIT-1:0] grp_base;
    logic [N_BIT-2:0] t;

    always_comb begin
        b_ext    = {1'b0, b_i};
        half     = ONE << s_i;
        k        = b_ext & (half - ONE);
        // (b >> s) * 2H is the group index with its low s bits cleared, doubled.
        grp_base = (b_ext & ~(half - ONE)) << 1;
        addr_a_o = grp_base + k;
        addr_b_o = addr_a_o + half;
        t        = (N_BIT - 1)'(twiddle_idx(32'(k), int'(s_i), N_BIT));
        rom_addr_o = t[A_BIT-1:0];
        quad_o     = t[N_BIT-2];
    end

endmodule

// File: rtl/fht_addr_gen.sv
// Stage/butterfly sequencer: issues ROM address and stage-zero flag, then the
// butterfly operand addresses one cycle later, aligned with the ROM output.
module fht_addr_gen
    import fht_addr_gen_pkg::*;
#(
    parameter int N_BIT = 8,
    parameter int A_BIT = N_BIT - 2,
    parameter int DRAIN = 4
) (
    input  logic                        iCLK,
    input  logic                        iRESET,
    input  logic                        iSTART,
    input  logic                        iEN,
    output logic [A_BIT-1:0]            oROM_ADDR,
    output logic                        oST_ZERO,
    output logic                        oQUAD,
    output logic [N_BIT-1:0]            oADDR_A,
    output logic [N_BIT-1:0]            oADDR_B,
    output logic [stage_w(N_BIT)-1:0]   oSTAGE,
    output logic                        oVALID,
    output logic                        oBUSY,
    output logic                        oDONE
);

    localparam int S_BIT = stage_w(N_BIT);

    localparam logic [N_BIT-2:0]       B_LAST   = '1;
    localparam logic [N_BIT-2:0]       B_ONE    = (N_BIT - 1)'(1);
    localparam logic [S_BIT-1:0]       S_LAST   = S_BIT'(N_BIT - 1);
    localparam logic [S_BIT-1:0]       S_ONE    = S_BIT'(1);
    localparam logic [DRAIN_CNT_W-1:0] CNT_ONE  = DRAIN_CNT_W'(1);
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LD = DRAIN_CNT_W'(DRAIN);

    seq_state_e             state_q, state_d;
    logic [S_BIT-1:0]       s_q, s_d;
    logic [N_BIT-2:0]       b_q, b_d;
    logic [DRAIN_CNT_W-1:0] cnt_q, cnt_d;
    logic                   st_zero_q, st_zero_d;
    logic                   stage_end;

    logic [N_BIT-1:0]       cur_a, cur_b;
    logic [A_BIT-1:0]       cur_rom;
    logic                   cur_quad;

    logic [N_BIT-1:0]       addr_a_q, addr_b_q;
    logic                   quad_q;
    logic [S_BIT-1:0]       stage_q;
    logic                   valid_q;
    logic                   done_q;

    // (s_q, b_q) is the butterfly whose ROM address is being issued this cycle.
    fht_bfly_idx #(
        .N_BIT (N_BIT),
        .A_BIT (A_BIT),
        .S_BIT (S_BIT)
    ) u_idx (
        .s_i        (s_q),
        .b_i        (b_q),
        .addr_a_o   (cur_a),
        .addr_b_o   (cur_b),
        .rom_addr_o (cur_rom),
        .quad_o     (cur_quad)
    );

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        stage_end = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (iSTART) begin
                    state_d = ST_RUN;
                    s_d     = '0;
                    b_d     = '0;
                end
            end
            ST_RUN: begin
                if (iEN) begin
                    if (b_q == B_LAST) begin
                        if (DRAIN == 0) begin
                            stage_end = 1'b1;
                        end else begin
                            state_d = ST_DRAIN;
                            cnt_d   = DRAIN_LD;
                        end
                    end else begin
                        b_d = b_q + B_ONE;
                    end
                end
            end
            ST_DRAIN: begin
                if (iEN) begin
                    if (cnt_q == CNT_ONE) begin
                        stage_end = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (stage_end) begin
            if (s_q == S_LAST) begin
                state_d = ST_DONE;
            end else begin
                state_d = ST_RUN;
                s_d     = s_q + S_ONE;
                b_d     = '0;
            end
        end

        st_zero_d = ((state_d == ST_RUN) || (state_d == ST_DRAIN)) && (s_d == '0);
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q   <= ST_IDLE;
            s_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            st_zero_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            st_zero_q <= st_zero_d;
            done_q    <= (state_q == ST_DONE);
        end
    end

    // Output delay register: captures the issued butterfly as the ROM registers its address.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            addr_a_q <= '0;
            addr_b_q <= '0;
            quad_q   <= 1'b0;
            stage_q  <= '0;
            valid_q  <= 1'b0;
        end else if (iEN) begin
            valid_q <= (state_q == ST_RUN);
            if (state_q == ST_RUN) begin
                addr_a_q <= cur_a;
                addr_b_q <= cur_b;
                quad_q   <= cur_quad;
                stage_q  <= s_q;
            end
        end
    end

    // A held beat stays in valid_q while iEN is low and is presented once iEN returns.
    assign oVALID    = valid_q & iEN;
    assign oROM_ADDR = cur_rom;
    assign oST_ZERO  = st_zero_q;
    assign oQUAD     = quad_q;
    assign oADDR_A   = addr_a_q;
    assign oADDR_B   = addr_b_q;
    assign oSTAGE    = stage_q;
    assign oDONE     = done_q;
    assign oBUSY     = (state_q != ST_IDLE) | done_q;

endmodule
